tb_crc24_attach: RTL

TB_CRC24_ATTACH -- requirements
Module: tb_crc24_attach

---
 rtl/tb_crc24_attach_if.sv | 24 ++
 rtl/tb_crc24_attach.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tb_crc24_attach_if.sv
// Bus bundle between the payload source, the CRC24 attach block and the coder stack.
// The master side drives size/payload strobes; the slave side returns the framed stream.
interface tb_crc24_attach_if;
    logic [15:0] size_in;
    logic        wreq_size_in;
    logic        data_in;
    logic        wreq_data_in;
    logic [15:0] tb_size_out;
    logic        wreq_size_out;
    logic        tb_out;
    logic        wreq_tb_out;
    logic        busy;
    logic        err;

    modport master (
        output size_in, wreq_size_in, data_in, wreq_data_in,
        input  tb_size_out, wreq_size_out, tb_out, wreq_tb_out, busy, err
    );

    modport slave (
        input  size_in, wreq_size_in, data_in, wreq_data_in,
        output tb_size_out, wreq_size_out, tb_out, wreq_tb_out, busy, err
    );
endinterface

// File: rtl/tb_crc24_attach.sv
// Serial transport-block CRC attach: forwards payload bits one cycle late and then
// appends CRC_LEN parity bits (MSB first), reporting the grown block size up front.
module tb_crc24_attach #(
    parameter int unsigned            CRC_LEN  = 24,
    parameter logic [CRC_LEN-1:0]     CRC_POLY = 24'h864CFB
) (
    input  logic               clk,
    input  logic               reset,
    tb_crc24_attach_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC
    } state_t;

    localparam logic [15:0] LEN16    = 16'(CRC_LEN);
    localparam logic [15:0] MAX_SIZE = 16'(32'd65535 - CRC_LEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CRC_LEN-1:0]   r_crc;
    logic [CRC_LEN-1:0]   w_crc_nxt;
    logic [CRC_LEN-1:0]   w_crc_step;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_nxt;
    logic [15:0]          w_cnt_inc;
    logic [15:0]          r_size;
    logic [15:0]          w_size_nxt;
    logic [15:0]          r_tb_size;
    logic [15:0]          w_tb_size_nxt;
    logic                 r_wreq_size;
    logic                 w_wreq_size_nxt;
    logic                 r_tb_out;
    logic                 w_tb_out_nxt;
    logic                 r_wreq_tb;
    logic                 w_wreq_tb_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_size_ok;
    logic                 w_fb;

    assign w_size_ok  = (bus.size_in != 16'd0) && (bus.size_in <= MAX_SIZE);
    assign w_fb       = bus.data_in ^ r_crc[CRC_LEN-1];
    assign w_crc_step = {r_crc[CRC_LEN-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    assign w_cnt_inc  = r_cnt + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_crc       <= '0;
            r_cnt       <= 16'd0;
            r_size      <= 16'd0;
            r_tb_size   <= 16'd0;
            r_wreq_size <= 1'b0;
            r_tb_out    <= 1'b0;
            r_wreq_tb   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_size      <= w_size_nxt;
            r_tb_size   <= w_tb_size_nxt;
            r_wreq_size <= w_wreq_size_nxt;
            r_tb_out    <= w_tb_out_nxt;
            r_wreq_tb   <= w_wreq_tb_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Error sets are evaluated after the accept clear so a stray strobe on the accept cycle still sticks.
    always_comb begin
        w_state_nxt     = r_state;
        w_crc_nxt       = r_crc;
        w_cnt_nxt       = r_cnt;
        w_size_nxt      = r_size;
        w_tb_size_nxt   = r_tb_size;
        w_wreq_size_nxt = 1'b0;
        w_tb_out_nxt    = 1'b0;
        w_wreq_tb_nxt   = 1'b0;
        w_err_nxt       = r_err;

        case (r_state)
            IDLE: begin
                if (bus.wreq_size_in) begin
                    if (w_size_ok) begin
                        w_size_nxt      = bus.size_in;
                        w_tb_size_nxt   = bus.size_in + LEN16;
                        w_wreq_size_nxt = 1'b1;
                        w_crc_nxt       = '0;
                        w_cnt_nxt       = 16'd0;
                        w_err_nxt       = 1'b0;
                        w_state_nxt     = DATA;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (bus.wreq_data_in) begin
                    w_err_nxt = 1'b1;
                end
            end

            DATA: begin
                w_tb_out_nxt  = bus.data_in;
                w_wreq_tb_nxt = bus.wreq_data_in;
                if (bus.wreq_data_in) begin
                    w_crc_nxt = w_crc_step;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_size) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = CRC;
                    end
                end
                if (bus.wreq_size_in) begin
                    w_err_nxt = 1'b1;
                end
            end

            CRC: begin
                // Shift the register out MSB first; the extra cycle after the last bit drops busy.
                if (r_cnt < LEN16) begin
                    w_tb_out_nxt  = r_crc[CRC_LEN-1];
                    w_wreq_tb_nxt = 1'b1;
                    w_crc_nxt     = {r_crc[CRC_LEN-2:0], 1'b0};
                    w_cnt_nxt     = w_cnt_inc;
                end else begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = IDLE;
                end
                if (bus.wreq_size_in || bus.wreq_data_in) begin
                    w_err_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tb_size_out   = r_tb_size;
    assign bus.wreq_size_out = r_wreq_size;
    assign bus.tb_out        = r_tb_out;
    assign bus.wreq_tb_out   = r_wreq_tb;
    assign bus.busy          = (r_state != IDLE);
    assign bus.err           = r_err;

endmodule
